// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed common-anode seven-segment driver for the scoreboard.
// Sequential double-dabble BCD converter, prescaled digit scan, and a timed
// game-over sequence (YOU / blank / LOSE / blank / score x4 / blank).
// Optional feature macro: SEG_LZB_EN enables leading-zero blanking of the score.
module seg_scan_display #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCORE_W     = 14,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_state,
  input  logic [SCORE_W-1:0] score,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic [DIGITS-1:0]  Anode_Activate,
  output logic [6:0]         LED_out,
  output logic               dp_out,
  output logic               bcd_busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned IW    = $clog2(DIGITS);
  localparam int unsigned RW    = $clog2(REFRESH_DIV);
  localparam int unsigned BW    = $clog2(BLINK_DIV);
  localparam int unsigned CW    = $clog2(SCORE_W);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned SAT_LIMIT = pow10(DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_Y     = 7'b1000100;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic {CV_CAPTURE, CV_SHIFT} conv_state_t;

  conv_state_t       conv_state;
  logic [BCD_W-1:0]  bcd_work;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_next;
  logic [BCD_W-1:0]  bcd_reg;
  logic [SCORE_W-1:0] bin_work;
  logic [CW-1:0]     bit_cnt;
  logic              sat;

  logic [RW-1:0]     refresh_cnt;
  logic [IW-1:0]     digit_idx;
  logic [BW-1:0]     blink_cnt;
  logic [3:0]        phase;

  logic [3:0]        cur_digit;
  logic              lead_zero;
  logic              score_view;
  logic [6:0]        seg_c;
  logic              dp_c;
  logic [DIGITS-1:0] anode_c;

  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin_work[SCORE_W-1]};
  end

  // Converter FSM: capture, SCORE_W steps, atomic commit on the last step, repeat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conv_state <= CV_CAPTURE;
      bcd_work   <= '0;
      bin_work   <= '0;
      bit_cnt    <= '0;
      sat        <= 1'b0;
      bcd_reg    <= '0;
      bcd_busy   <= 1'b0;
    end else begin
      case (conv_state)
        CV_CAPTURE: begin
          bin_work   <= score;
          bcd_work   <= '0;
          bit_cnt    <= '0;
          sat        <= (32'(score) >= SAT_LIMIT);
          bcd_busy   <= 1'b1;
          conv_state <= CV_SHIFT;
        end
        CV_SHIFT: begin
          bcd_work <= bcd_next;
          bin_work <= {bin_work[SCORE_W-2:0], 1'b0};
          bit_cnt  <= bit_cnt + CW'(1);
          // a carry out of the BCD field can only come from an over-range score
          sat      <= sat | bcd_adj[BCD_W-1];
          if (bit_cnt == CW'(SCORE_W - 1)) begin
            bcd_reg    <= (sat | bcd_adj[BCD_W-1]) ? {DIGITS{4'h9}} : bcd_next;
            bcd_busy   <= 1'b0;
            conv_state <= CV_CAPTURE;
          end
        end
        default: conv_state <= CV_CAPTURE;
      endcase
    end
  end

  // Digit scan prescaler and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Game-over phase machine; held at phase 0 while playing so a new game over starts fresh
  always_ff @(posedge clk) begin
    if (!rst_n || game_state) begin
      blink_cnt <= '0;
      phase     <= 4'd0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= (phase == 4'd8) ? 4'd0 : phase + 4'd1;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign cur_digit = bcd_reg[{digit_idx, 2'b00} +: 4];
  assign anode_c   = ~(DIGITS'(1) << digit_idx);

`ifdef SEG_LZB_EN
  assign lead_zero = (digit_idx != '0) && ((bcd_reg >> {digit_idx, 2'b00}) == '0);
`else
  assign lead_zero = 1'b0;
`endif

  // Glyph and decimal-point selection for the digit currently being scanned
  always_comb begin
    seg_c      = SEG_BLANK;
    dp_c       = 1'b1;
    score_view = game_state || ((phase >= 4'd4) && (phase <= 4'd7));
    if (score_view) begin
      if (!lead_zero) begin
        seg_c = digit_glyph(cur_digit);
        dp_c  = ~dp_mask[digit_idx];
      end
    end else if (phase == 4'd0) begin
      case (digit_idx)
        IW'(0):  seg_c = SEG_U;
        IW'(1):  seg_c = SEG_O;
        IW'(2):  seg_c = SEG_Y;
        default: seg_c = SEG_BLANK;
      endcase
    end else if (phase == 4'd2) begin
      case (digit_idx)
        IW'(0):  seg_c = SEG_E;
        IW'(1):  seg_c = SEG_S;
        IW'(2):  seg_c = SEG_O;
        IW'(3):  seg_c = SEG_L;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Anode_Activate <= '1;
      LED_out        <= SEG_BLANK;
      dp_out         <= 1'b1;
    end else begin
      Anode_Activate <= anode_c;
      LED_out        <= seg_c;
      dp_out         <= dp_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: randomized and directed stimulus compared every
// cycle against an arithmetic model of the scoreboard display.
module tb_seg_scan_display;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned SCORE_W     = 14;
  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 16;
  localparam int          CONV_LEN    = SCORE_W + 1;
  localparam int          MAX_SHOWN   = 9999;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               game_state;
  logic [SCORE_W-1:0] score;
  logic [DIGITS-1:0]  dp_mask;
  logic [DIGITS-1:0]  anode;
  logic [6:0]         led;
  logic               dp;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int t_rel     = 0;
  int model_val = 0;
  int cap_val   = 0;
  int go_cnt    = 0;

  logic [6:0] digit_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

  always #5 clk = ~clk;

  seg_scan_display #(
    .DIGITS(DIGITS), .SCORE_W(SCORE_W), .REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_state(game_state), .score(score), .dp_mask(dp_mask),
    .Anode_Activate(anode), .LED_out(led), .dp_out(dp), .bcd_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected glyph for one digit slot, from the displayed decimal value and phase
  function automatic void model_out(input int dig, input int val, input int ph,
                                    input logic playing, input logic [3:0] mask,
                                    output logic [6:0] seg, output logic dpx);
    int  p10;
    int  digit;
    bit  blank;
    p10 = 1;
    for (int i = 0; i < dig; i++) p10 = p10 * 10;
    digit = (val / p10) % 10;
    blank = 1'b0;
`ifdef SEG_LZB_EN
    blank = (dig > 0) && ((val / p10) == 0);
`endif
    seg = 7'b1111111;
    dpx = 1'b1;
    if (playing || (ph >= 4 && ph <= 7)) begin
      if (!blank) begin
        seg = digit_tab[digit];
        dpx = ~mask[dig];
      end
    end else if (ph == 0) begin
      if (dig == 2) seg = 7'b1000100;
      else if (dig == 1) seg = 7'b0000001;
      else if (dig == 0) seg = 7'b1000001;
    end else if (ph == 2) begin
      if (dig == 3) seg = 7'b1110001;
      else if (dig == 2) seg = 7'b0000001;
      else if (dig == 1) seg = 7'b0100100;
      else seg = 7'b0110000;
    end
  endfunction

  // One clock: predict the post-edge outputs, then compare them 1 time unit later
  task automatic step();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_busy;
    int         dig;
    int         ph;
    @(posedge clk);
    if (!rst_n) begin
      t_rel     = 0;
      model_val = 0;
      go_cnt    = 0;
      exp_an    = 4'b1111;
      exp_seg   = 7'b1111111;
      exp_dp    = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      t_rel++;
      dig    = ((t_rel - 1) / REFRESH_DIV) % DIGITS;
      ph     = (go_cnt / BLINK_DIV) % 9;
      exp_an = ~(4'b0001 << dig);
      model_out(dig, model_val, ph, game_state, dp_mask, exp_seg, exp_dp);
      go_cnt = game_state ? 0 : go_cnt + 1;
      if (t_rel % CONV_LEN == 1) cap_val = int'(score);
      if (t_rel % CONV_LEN == 0) model_val = (cap_val > MAX_SHOWN) ? MAX_SHOWN : cap_val;
      exp_busy = (t_rel % CONV_LEN) != 0;
    end
    #1;
    check("anode", 32'(anode), 32'(exp_an));
    check("seg", 32'(led), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("busy", 32'(busy), 32'(exp_busy));
    if (rst_n) check("one_anode_low", 32'($countones(~anode)), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    game_state = 1'b1;
    score      = '0;
    dp_mask    = '0;
    repeat (3) step();

    // First edge after release selects digit 0 showing "0"
    rst_n = 1'b1;
    step();
    check("first_anode", 32'(anode), 32'h0000000e);
    check("boot_digit0", 32'(led), 32'h00000001);

    // Score display
    score = 14'd1234;
    repeat (60) step();

    // Saturation with decimal point on digit 2
    score   = 14'd12000;
    dp_mask = 4'b0100;
    repeat (50) step();

    // Game-over sequence over two full periods, then resume play
    game_state = 1'b0;
    score      = 14'd1234;
    dp_mask    = 4'b0001;
    repeat (310) step();
    game_state = 1'b1;
    repeat (20) step();

    // Small values exercise leading zeros
    score = 14'd7;
    repeat (45) step();
    score = 14'd0;
    repeat (45) step();

    // Reset in the middle of a conversion
    score = 14'd42;
    repeat (20) step();
    score = 14'd9999;
    repeat (5) step();
    rst_n = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (40) step();

    // Reset in the middle of a game-over phase
    game_state = 1'b0;
    repeat (50) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (200) step();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      score      = SCORE_W'($urandom_range(0, 16383));
      dp_mask    = DIGITS'($urandom);
      game_state = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 4)) step();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(5, 90)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
